// File: rtl/fir_filter.sv
// 4-tap direct-form FIR filter: one signed sample per clock in, full-precision registered result out.
// Optional FIR_COEF_LOAD_EN: coefficients become run-time writable registers that reset to C0..C3.
module fir_filter #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 4,
  parameter int OW   = 18,
  parameter int C0   = 16,
  parameter int C1   = 48,
  parameter int C2   = 48,
  parameter int C3   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] data_in,
`ifdef FIR_COEF_LOAD_EN
  input  logic                 coef_we,
  input  logic        [1:0]    coef_addr,
  input  logic signed [CW-1:0] coef_data,
`endif
  output logic signed [OW-1:0] data_out
);

  localparam logic signed [CW-1:0] COEF_RST [TAPS] = '{CW'(C0), CW'(C1), CW'(C2), CW'(C3)};

  logic signed [DW-1:0] dly  [TAPS-1];
  logic signed [DW-1:0] taps [TAPS];
  logic signed [CW-1:0] coef [TAPS];
  logic signed [OW-1:0] acc;

  // Both operands widened to OW first, so the OW-bit product and sum are exact.
  function automatic logic signed [OW-1:0] mac_term(input logic signed [DW-1:0] x,
                                                    input logic signed [CW-1:0] c);
    logic signed [OW-1:0] xe;
    logic signed [OW-1:0] ce;
    xe = {{(OW-DW){x[DW-1]}}, x};
    ce = {{(OW-CW){c[CW-1]}}, c};
    return xe * ce;
  endfunction

  always_comb begin
    taps[0] = data_in;
    for (int i = 1; i < TAPS; i++) taps[i] = dly[i-1];
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + mac_term(taps[i], coef[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS-1; i++) dly[i] <= '0;
      data_out <= '0;
    end else begin
      dly[0] <= data_in;
      for (int i = 1; i < TAPS-1; i++) dly[i] <= dly[i-1];
      data_out <= acc;
    end
  end

`ifdef FIR_COEF_LOAD_EN
  // Reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= COEF_RST[i];
    end else if (coef_we) begin
      coef[coef_addr] <= coef_data;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < TAPS; i++) coef[i] = COEF_RST[i];
  end
`endif

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: scoreboard of expected outputs, one task per scenario.
// Build with +define+FIR_COEF_LOAD_EN to also exercise run-time coefficient loading.
`timescale 1ns/1ps
module tb_fir_filter;

  logic               clk;
  logic               rst;
  logic signed [7:0]  data_in;
  logic signed [17:0] data_out;
`ifdef FIR_COEF_LOAD_EN
  logic               coef_we;
  logic        [1:0]  coef_addr;
  logic signed [7:0]  coef_data;
`endif

  logic signed [17:0] sb [$];
  logic signed [17:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: sample history and nominal coefficients.
  int mh [3];
  int mc [4] = '{16, 48, 48, 16};
  int mexp;

  fir_filter dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
`ifdef FIR_COEF_LOAD_EN
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
`endif
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int x, input bit r);
    data_in = 8'(x);
    rst     = r;
    if (!r) begin
      mh   = '{0, 0, 0};
      mexp = 0;
    end else begin
      mexp  = mc[0]*x + mc[1]*mh[0] + mc[2]*mh[1] + mc[3]*mh[2];
      mh[2] = mh[1];
      mh[1] = mh[0];
      mh[0] = x;
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(-6, 1'b0);
      sb.push_back(18'sd0);
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1);
      sb.push_back(18'sd0);
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL reset_flush[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_impulse();
    int xs [6] = '{1, 0, 0, 0, 0, 0};
    int es [6] = '{16, 48, 48, 16, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(xs[i], 1'b1);
      sb.push_back(18'(es[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL impulse[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_step();
    int es [7] = '{2032, 8128, 14224, 16256, 16256, 16256, 16256};
    for (int i = 0; i < 7; i++) begin
      drive(127, 1'b1);
      sb.push_back(18'(es[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL step[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int xs [5] = '{55, 1, 0, 0, 0};
    bit rs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int es [5] = '{0, 16, 48, 48, 16};
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], rs[i]);
      sb.push_back(18'(es[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_neg_full();
    int es [6] = '{-2048, -8192, -14336, -16384, -16384, -16384};
    for (int i = 0; i < 6; i++) begin
      drive(-128, 1'b1);
      sb.push_back(18'(es[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL neg_full[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
    n_checks++;
    if (data_out !== 18'h3C000) begin
      n_fail++;
      $display("FAIL neg_full_hex: data_out=%h required=3c000", data_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      drive(int'($urandom_range(255)) - 128, 1'b1);
      sb.push_back(18'(mexp));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic test_coef_load();
    int es_a [4] = '{-1, 48, 48, 16};
    int es_b [4] = '{16, 48, 48, 16};
    int es_c [4] = '{16384, 32768, 49152, 65536};
    int xs   [4] = '{1, 0, 0, 0};
    // Reset with a concurrent write: the write must be dropped.
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd5;
    drive(0, 1'b0);
    edge_wait();
    coef_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], 1'b1);
      sb.push_back(18'(es_b[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL coef_wr_in_reset[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = -8'sd1;
    drive(0, 1'b1);
    edge_wait();
    coef_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], 1'b1);
      sb.push_back(18'(es_a[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL coef_tap0[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
    drive(0, 1'b0);
    edge_wait();
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], 1'b1);
      sb.push_back(18'(es_b[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL coef_revert[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
    for (int t = 0; t < 4; t++) begin
      coef_we = 1'b1; coef_addr = 2'(t); coef_data = -8'sd128;
      drive(0, 1'b1);
      edge_wait();
    end
    coef_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(-128, 1'b1);
      sb.push_back(18'(es_c[i]));
      edge_wait();
      exp_v = sb.pop_front();
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++;
        $display("FAIL coef_max[%0d]: data_out=%0d required=%0d", i, data_out, exp_v);
      end
    end
    drive(0, 1'b0);
    edge_wait();
  endtask
`endif

  initial begin
    rst = 1'b0;
    data_in = '0;
    mh = '{0, 0, 0};
    mexp = 0;
`ifdef FIR_COEF_LOAD_EN
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
`endif
    @(negedge clk);
    test_reset();
    test_impulse();
    test_step();
    test_reset_mid();
    test_neg_full();
    test_random();
`ifdef FIR_COEF_LOAD_EN
    test_coef_load();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
